// File: rtl/spim_regs_fifo_pkg.sv
// Shared constants for the SPI master register bank: register addresses,
// bit positions inside CTRL/STATUS/IE/CMD, and the divisor reset value.
package spim_pkg;

    localparam logic [3:0] ADDR_DIVL   = 4'h0;
    localparam logic [3:0] ADDR_DIVH   = 4'h1;
    localparam logic [3:0] ADDR_CTRL   = 4'h2;
    localparam logic [3:0] ADDR_DATA   = 4'h3;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CS     = 4'h5;
    localparam logic [3:0] ADDR_IE     = 4'h6;
    localparam logic [3:0] ADDR_CMD    = 4'h7;
    localparam logic [3:0] ADDR_TXLVL  = 4'h8;
    localparam logic [3:0] ADDR_RXLVL  = 4'h9;

    localparam int CTRL_SPE   = 7;
    localparam int CTRL_CPOL  = 3;
    localparam int CTRL_CPHA  = 2;
    localparam int CTRL_LSBFE = 0;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_BUSY     = 4;
    localparam int ST_RX_OVR   = 5;
    localparam int ST_TX_OVR   = 6;

    localparam int IE_TXE  = 0;
    localparam int IE_RXNE = 2;
    localparam int IE_OVR  = 5;

    localparam int CMD_FLUSH_TX = 0;
    localparam int CMD_FLUSH_RX = 1;
    localparam int CMD_CLR_OVR  = 2;

    localparam logic [15:0] DIV_RESET = 16'h0001;

endpackage

// File: rtl/spim_regs_fifo_sync_fifo.sv
// Small synchronous FIFO used for both the TX and RX byte queues.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise the byte is dropped and 'drop' pulses. Flush wins over
// any same-cycle push or pop. The head reads 0 while the FIFO is empty.
module spim_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       CLK_i,
    input  logic                       RST_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok & ~flush;
    assign level   = count;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + LW'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - LW'(1);
            end
        end
    end

    // Storage array; contents need no reset because the head is masked while empty.
    always_ff @(posedge CLK_i) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/spim_regs_fifo.sv
// Host-side register bank for the SPI master: divisor, control, chip
// selects, interrupt enables, TX/RX byte FIFOs with sticky overrun flags,
// and a registered interrupt. The engine consumes TX bytes through a
// valid/ack handshake and delivers RX bytes with a one-cycle strobe.
module spim_regs_fifo
    import spim_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_CS     = 8
) (
    input  logic              CLK_i,
    input  logic              RST_i,
    input  logic              RST_SYNC_i,
    input  logic              WR_i,
    input  logic              RD_i,
    input  logic [3:0]        AD_i,
    input  logic [7:0]        Data_i,
    output logic [7:0]        Data_o,
    output logic [15:0]       Divisor_o,
    output logic              SPE_o,
    output logic              CPOL_o,
    output logic              CPHA_o,
    output logic              LSBFE_o,
    output logic [NUM_CS-1:0] CS_o,
    output logic [7:0]        TX_Data_o,
    output logic              TX_Valid_o,
    input  logic              TX_Ack_i,
    input  logic [7:0]        RX_Data_i,
    input  logic              RX_Valid_i,
    input  logic              Busy_i,
    output logic              INTR_o
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]       div_q;
    logic              spe_q;
    logic              cpol_q;
    logic              cpha_q;
    logic              lsbfe_q;
    logic [NUM_CS-1:0] cs_q;
    logic              ie_txe_q;
    logic              ie_rxne_q;
    logic              ie_ovr_q;
    logic              tx_ovr_q;
    logic              rx_ovr_q;
    logic              intr_q;

    logic              wr_data;
    logic              rd_data;
    logic              wr_cmd;
    logic              flush_tx;
    logic              flush_rx;
    logic              clr_ovr;

    logic [7:0]        tx_head;
    logic              tx_full;
    logic              tx_empty;
    logic [LW-1:0]     tx_level;
    logic              tx_drop;
    logic [7:0]        rx_head;
    logic              rx_full;
    logic              rx_empty;
    logic [LW-1:0]     rx_level;
    logic              rx_drop;

    logic [7:0]        status;
    logic [7:0]        cs_ext;
    logic [7:0]        ie_ext;

    assign wr_data  = WR_i & (AD_i == ADDR_DATA);
    assign rd_data  = RD_i & (AD_i == ADDR_DATA);
    assign wr_cmd   = WR_i & (AD_i == ADDR_CMD);
    assign flush_tx = RST_SYNC_i | (wr_cmd & Data_i[CMD_FLUSH_TX]);
    assign flush_rx = RST_SYNC_i | (wr_cmd & Data_i[CMD_FLUSH_RX]);
    assign clr_ovr  = wr_cmd & Data_i[CMD_CLR_OVR];

    spim_sync_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .CLK_i (CLK_i),
        .RST_i (RST_i),
        .push  (wr_data),
        .pop   (TX_Ack_i),
        .flush (flush_tx),
        .wdata (Data_i),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level),
        .drop  (tx_drop)
    );

    spim_sync_fifo #(
        .W     (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .CLK_i (CLK_i),
        .RST_i (RST_i),
        .push  (RX_Valid_i),
        .pop   (rd_data),
        .flush (flush_rx),
        .wdata (RX_Data_i),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level),
        .drop  (rx_drop)
    );

    // Host-writable configuration registers; the synchronous reset restores the same values as RST_i.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            div_q     <= DIV_RESET;
            spe_q     <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsbfe_q   <= 1'b0;
            cs_q      <= '0;
            ie_txe_q  <= 1'b0;
            ie_rxne_q <= 1'b0;
            ie_ovr_q  <= 1'b0;
        end else if (RST_SYNC_i) begin
            div_q     <= DIV_RESET;
            spe_q     <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            lsbfe_q   <= 1'b0;
            cs_q      <= '0;
            ie_txe_q  <= 1'b0;
            ie_rxne_q <= 1'b0;
            ie_ovr_q  <= 1'b0;
        end else if (WR_i) begin
            case (AD_i)
                ADDR_DIVL: div_q[7:0]  <= Data_i;
                ADDR_DIVH: div_q[15:8] <= Data_i;
                ADDR_CTRL: begin
                    spe_q   <= Data_i[CTRL_SPE];
                    cpol_q  <= Data_i[CTRL_CPOL];
                    cpha_q  <= Data_i[CTRL_CPHA];
                    lsbfe_q <= Data_i[CTRL_LSBFE];
                end
                ADDR_CS: cs_q <= Data_i[NUM_CS-1:0];
                ADDR_IE: begin
                    ie_txe_q  <= Data_i[IE_TXE];
                    ie_rxne_q <= Data_i[IE_RXNE];
                    ie_ovr_q  <= Data_i[IE_OVR];
                end
                default: ;
            endcase
        end
    end

    // Sticky overrun flags; a CMD clear in the same cycle outranks a new drop.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            tx_ovr_q <= 1'b0;
            rx_ovr_q <= 1'b0;
        end else if (RST_SYNC_i || clr_ovr) begin
            tx_ovr_q <= 1'b0;
            rx_ovr_q <= 1'b0;
        end else begin
            if (tx_drop) begin
                tx_ovr_q <= 1'b1;
            end
            if (rx_drop) begin
                rx_ovr_q <= 1'b1;
            end
        end
    end

    // Interrupt is registered from the current FIFO and flag state, gated by SPE.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            intr_q <= 1'b0;
        end else if (RST_SYNC_i) begin
            intr_q <= 1'b0;
        end else begin
            intr_q <= spe_q & ((ie_txe_q & tx_empty) |
                               (ie_rxne_q & ~rx_empty) |
                               (ie_ovr_q & (rx_ovr_q | tx_ovr_q)));
        end
    end

    // Read-side views of STATUS, CS and IE zero-extended to the byte bus.
    always_comb begin
        status              = '0;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_BUSY]     = Busy_i;
        status[ST_RX_OVR]   = rx_ovr_q;
        status[ST_TX_OVR]   = tx_ovr_q;
        cs_ext              = '0;
        cs_ext[NUM_CS-1:0]  = cs_q;
        ie_ext              = '0;
        ie_ext[IE_TXE]      = ie_txe_q;
        ie_ext[IE_RXNE]     = ie_rxne_q;
        ie_ext[IE_OVR]      = ie_ovr_q;
    end

    // Combinational read mux; unmapped and write-only addresses read as zero.
    always_comb begin
        Data_o = 8'h00;
        case (AD_i)
            ADDR_DIVL:   Data_o = div_q[7:0];
            ADDR_DIVH:   Data_o = div_q[15:8];
            ADDR_CTRL:   Data_o = {spe_q, 3'b000, cpol_q, cpha_q, 1'b0, lsbfe_q};
            ADDR_DATA:   Data_o = rx_head;
            ADDR_STATUS: Data_o = status;
            ADDR_CS:     Data_o = cs_ext;
            ADDR_IE:     Data_o = ie_ext;
            ADDR_TXLVL:  Data_o = 8'(tx_level);
            ADDR_RXLVL:  Data_o = 8'(rx_level);
            default:     Data_o = 8'h00;
        endcase
    end

    assign Divisor_o  = div_q;
    assign SPE_o      = spe_q;
    assign CPOL_o     = cpol_q;
    assign CPHA_o     = cpha_q;
    assign LSBFE_o    = lsbfe_q;
    assign CS_o       = cs_q;
    assign TX_Data_o  = tx_head;
    assign TX_Valid_o = spe_q & ~tx_empty;
    assign INTR_o     = intr_q;

endmodule

// File: tb/tb_spim_regs_fifo.sv
// Scoreboard bench for spim_regs_fifo: stimulus pushes the responses a
// queue-based reference model predicts for each cycle; a monitor on the
// falling edge pops and compares them against the DUT outputs.
module tb_spim_regs_fifo;

   localparam int D   = 4;
   localparam int NCS = 8;

   logic           CLK_i;
   logic           RST_i;
   logic           RST_SYNC_i;
   logic           WR_i;
   logic           RD_i;
   logic [3:0]     AD_i;
   logic [7:0]     Data_i;
   logic [7:0]     Data_o;
   logic [15:0]    Divisor_o;
   logic           SPE_o;
   logic           CPOL_o;
   logic           CPHA_o;
   logic           LSBFE_o;
   logic [NCS-1:0] CS_o;
   logic [7:0]     TX_Data_o;
   logic           TX_Valid_o;
   logic           TX_Ack_i;
   logic [7:0]     RX_Data_i;
   logic           RX_Valid_i;
   logic           Busy_i;
   logic           INTR_o;

   spim_regs_fifo #(
      .FIFO_DEPTH (D),
      .NUM_CS     (NCS)
   ) dut (
      .CLK_i      (CLK_i),
      .RST_i      (RST_i),
      .RST_SYNC_i (RST_SYNC_i),
      .WR_i       (WR_i),
      .RD_i       (RD_i),
      .AD_i       (AD_i),
      .Data_i     (Data_i),
      .Data_o     (Data_o),
      .Divisor_o  (Divisor_o),
      .SPE_o      (SPE_o),
      .CPOL_o     (CPOL_o),
      .CPHA_o     (CPHA_o),
      .LSBFE_o    (LSBFE_o),
      .CS_o       (CS_o),
      .TX_Data_o  (TX_Data_o),
      .TX_Valid_o (TX_Valid_o),
      .TX_Ack_i   (TX_Ack_i),
      .RX_Data_i  (RX_Data_i),
      .RX_Valid_i (RX_Valid_i),
      .Busy_i     (Busy_i),
      .INTR_o     (INTR_o)
   );

   initial CLK_i = 1'b0;
   always #5 CLK_i = ~CLK_i;

   logic [15:0] m_div;
   bit          m_spe, m_cpol, m_cpha, m_lsbfe;
   logic [7:0]  m_cs;
   bit          m_ie0, m_ie2, m_ie5;
   bit          m_txovr, m_rxovr, m_intr;
   logic [7:0]  txq[$];
   logic [7:0]  rxq[$];

   int          kindq[$];
   logic [15:0] expq[$];
   int          passed = 0;
   int          total  = 0;

   function automatic string kindName(int k);
      case (k)
         0: return "Data_o";
         1: return "INTR_o";
         2: return "TX_Valid_o";
         3: return "TX_Data_o";
         4: return "Divisor_o";
         5: return "CS_o";
         6: return "CTRL_outputs";
         default: return "Data_o_directed";
      endcase
   endfunction

   task automatic modelReset();
      m_div = 16'h0001;
      m_spe = 0; m_cpol = 0; m_cpha = 0; m_lsbfe = 0;
      m_cs = 8'h00;
      m_ie0 = 0; m_ie2 = 0; m_ie5 = 0;
      m_txovr = 0; m_rxovr = 0; m_intr = 0;
      txq.delete();
      rxq.delete();
   endtask

   function automatic logic [7:0] modelRead(logic [3:0] a, bit busy);
      case (a)
         4'h0: return m_div[7:0];
         4'h1: return m_div[15:8];
         4'h2: return {m_spe, 3'b000, m_cpol, m_cpha, 1'b0, m_lsbfe};
         4'h3: return (rxq.size() > 0) ? rxq[0] : 8'h00;
         4'h4: return {1'b0, m_txovr, m_rxovr, busy,
                       rxq.size() == D, rxq.size() == 0,
                       txq.size() == D, txq.size() == 0};
         4'h5: return m_cs;
         4'h6: return {2'b00, m_ie5, 2'b00, m_ie2, 1'b0, m_ie0};
         4'h8: return 8'(txq.size());
         4'h9: return 8'(rxq.size());
         default: return 8'h00;
      endcase
   endfunction

   task automatic modelStep(bit wr, bit rd, logic [3:0] ad, logic [7:0] din,
                            bit ack, bit rxv, logic [7:0] rxd, bit rs);
      bit intr_next, cmd, ftx, frx, clr, tpop, rpop, tset, rset;
      int tsz, rsz;
      if (rs) begin
         modelReset();
         return;
      end
      intr_next = m_spe && ((m_ie0 && txq.size() == 0) ||
                            (m_ie2 && rxq.size() != 0) ||
                            (m_ie5 && (m_rxovr || m_txovr)));
      cmd  = wr && (ad == 4'h7);
      ftx  = cmd && din[0];
      frx  = cmd && din[1];
      clr  = cmd && din[2];
      tset = 0;
      rset = 0;
      tsz  = txq.size();
      rsz  = rxq.size();
      if (ftx) begin
         txq.delete();
      end else begin
         tpop = ack && (tsz > 0);
         if (tpop) void'(txq.pop_front());
         if (wr && ad == 4'h3) begin
            if (tsz < D || tpop) txq.push_back(din);
            else tset = 1;
         end
      end
      if (frx) begin
         rxq.delete();
      end else begin
         rpop = rd && (ad == 4'h3) && (rsz > 0);
         if (rpop) void'(rxq.pop_front());
         if (rxv) begin
            if (rsz < D || rpop) rxq.push_back(rxd);
            else rset = 1;
         end
      end
      if (clr) begin
         m_txovr = 0;
         m_rxovr = 0;
      end else begin
         if (tset) m_txovr = 1;
         if (rset) m_rxovr = 1;
      end
      if (wr) begin
         case (ad)
            4'h0: m_div[7:0]  = din;
            4'h1: m_div[15:8] = din;
            4'h2: begin
               m_spe = din[7]; m_cpol = din[3]; m_cpha = din[2]; m_lsbfe = din[0];
            end
            4'h5: m_cs = din;
            4'h6: begin
               m_ie0 = din[0]; m_ie2 = din[2]; m_ie5 = din[5];
            end
            default: ;
         endcase
      end
      m_intr = intr_next;
   endtask

   task automatic pushExp(int k, logic [15:0] v);
      kindq.push_back(k);
      expq.push_back(v);
   endtask

   task automatic checkOutput(int expRd);
      pushExp(0, {8'h00, modelRead(AD_i, Busy_i)});
      pushExp(1, {15'h0, m_intr});
      pushExp(2, {15'h0, m_spe && txq.size() > 0});
      if (txq.size() > 0) pushExp(3, {8'h00, txq[0]});
      pushExp(4, m_div);
      pushExp(5, {8'h00, m_cs});
      pushExp(6, {12'h0, m_spe, m_cpol, m_cpha, m_lsbfe});
      if (expRd >= 0) pushExp(7, 16'(expRd));
   endtask

   task automatic applyStimulus(bit wr, bit rd, logic [3:0] ad, logic [7:0] din,
                                bit ack, bit rxv, logic [7:0] rxd, bit busy,
                                bit rs, int expRd);
      WR_i       = wr;
      RD_i       = rd;
      AD_i       = ad;
      Data_i     = din;
      TX_Ack_i   = ack;
      RX_Valid_i = rxv;
      RX_Data_i  = rxd;
      Busy_i     = busy;
      RST_SYNC_i = rs;
      checkOutput(expRd);
      modelStep(wr, rd, ad, din, ack, rxv, rxd, rs);
      @(posedge CLK_i);
      #1;
   endtask

   task automatic writeReg(logic [3:0] a, logic [7:0] d);
      applyStimulus(1, 0, a, d, 0, 0, 8'h00, 0, 0, -1);
   endtask

   task automatic readReg(logic [3:0] a, int expv);
      applyStimulus(0, 1, a, 8'h00, 0, 0, 8'h00, 0, 0, expv);
   endtask

   task automatic ackTx();
      applyStimulus(0, 0, 4'h4, 8'h00, 1, 0, 8'h00, 1, 0, -1);
   endtask

   task automatic rxByte(logic [7:0] d);
      applyStimulus(0, 0, 4'h4, 8'h00, 0, 1, d, 0, 0, -1);
   endtask

   task automatic doReset();
      RST_i = 1'b1; RST_SYNC_i = 0; WR_i = 0; RD_i = 0; AD_i = 0; Data_i = 0;
      TX_Ack_i = 0; RX_Valid_i = 0; RX_Data_i = 0; Busy_i = 0;
      repeat (2) @(posedge CLK_i);
      #1;
      RST_i = 1'b0;
      modelReset();
   endtask

   task automatic checkReset();
      logic [63:0] got;
      logic [63:0] exp;
      AD_i = 4'h4;
      #1;
      got = {INTR_o, TX_Valid_o, Divisor_o, 8'(CS_o), SPE_o, CPOL_o, CPHA_o, LSBFE_o, Data_o, 20'h0};
      exp = {1'b0, 1'b0, 16'h0001, 8'h00, 4'b0000, 8'h05, 20'h0};
      total++;
      if (got === exp) passed++;
      else $display("[TB] FAIL reset state: got 0x%0h expected 0x%0h at %0t", got, exp, $time);
   endtask

   task automatic waitIntr(bit level, int maxCycles);
      int n;
      n = 0;
      while (INTR_o !== level && n < maxCycles) begin
         applyStimulus(0, 0, 4'h4, 8'h00, 0, 0, 8'h00, 0, 0, -1);
         n++;
      end
      total++;
      if (INTR_o === level) passed++;
      else $display("[TB] FAIL wait for INTR_o=%0b expired after %0d cycles at %0t",
                    level, n, $time);
   endtask

   // Monitor compares every queued prediction against the DUT on the falling edge
   always @(negedge CLK_i) begin
      int k;
      logic [15:0] e;
      logic [15:0] a;
      while (kindq.size() > 0) begin
         k = kindq.pop_front();
         e = expq.pop_front();
         case (k)
            1: a = {15'h0, INTR_o};
            2: a = {15'h0, TX_Valid_o};
            3: a = {8'h00, TX_Data_o};
            4: a = Divisor_o;
            5: a = {8'h00, CS_o};
            6: a = {12'h0, SPE_o, CPOL_o, CPHA_o, LSBFE_o};
            default: a = {8'h00, Data_o};
         endcase
         total++;
         if (a === e) passed++;
         else $display("[TB] FAIL %s AD=%0h: got 0x%0h expected 0x%0h at %0t",
                       kindName(k), AD_i, a, e, $time);
      end
   end

   int rst_exp[10] = '{1, 0, 0, 0, 5, 0, 0, 0, 0, 0};
   logic [7:0] tx_bytes[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

   // Directed scenarios from the test plan followed by randomized traffic
   initial begin
      bit wr, rd, ack, rxv, rs, busy;
      logic [3:0] ad;
      doReset();
      checkReset();
      $display("[TB] reset register readback");
      for (int i = 0; i < 10; i++) readReg(4'(i), rst_exp[i]);

      $display("[TB] TX fill and overrun");
      writeReg(4'h2, 8'h80);
      for (int i = 0; i < 5; i++) writeReg(4'h3, tx_bytes[i]);
      readReg(4'h4, 8'h46);
      readReg(4'h8, 4);
      repeat (4) ackTx();
      readReg(4'h4, 8'h45);

      $display("[TB] push into full TX with same-cycle ack");
      writeReg(4'h7, 8'h04);
      for (int i = 0; i < 4; i++) writeReg(4'h3, 8'hA0 + 8'(i));
      applyStimulus(1, 0, 4'h3, 8'h66, 1, 0, 8'h00, 0, 0, -1);
      readReg(4'h4, 8'h06);
      readReg(4'h8, 4);
      repeat (3) ackTx();
      readReg(4'h8, 1);
      ackTx();

      $display("[TB] RX interrupt and pops");
      writeReg(4'h6, 8'h04);
      rxByte(8'hA5);
      waitIntr(1'b1, 4);
      rxByte(8'h5A);
      readReg(4'h3, 8'hA5);
      readReg(4'h3, 8'h5A);
      readReg(4'h9, 0);
      waitIntr(1'b0, 4);
      readReg(4'h3, 0);

      $display("[TB] RX overrun, clear and flush");
      for (int i = 0; i < 5; i++) rxByte(8'(8'hC0 + i));
      readReg(4'h4, 8'h29);
      writeReg(4'h6, 8'h20);
      readReg(4'h9, 4);
      writeReg(4'h7, 8'h04);
      writeReg(4'h7, 8'h02);
      readReg(4'h4, 8'h05);

      $display("[TB] synchronous reset mid-transfer");
      writeReg(4'h0, 8'h34);
      writeReg(4'h5, 8'h5A);
      for (int i = 0; i < 3; i++) writeReg(4'h3, 8'h70 + 8'(i));
      rxByte(8'h99);
      applyStimulus(0, 0, 4'h8, 8'h00, 1, 1, 8'h77, 1, 1, 3);
      readReg(4'h8, 0);
      readReg(4'h9, 0);
      readReg(4'h0, 1);

      $display("[TB] randomized traffic");
      writeReg(4'h2, 8'h80);
      for (int n = 0; n < 3000; n++) begin
         wr   = ($urandom % 4) == 0;
         rd   = ($urandom % 3) == 0;
         ack  = ($urandom % 3) == 0;
         rxv  = ($urandom % 3) == 0;
         busy = ($urandom % 2) == 0;
         rs   = ($urandom % 600) == 0;
         ad   = (($urandom % 2) == 0) ? 4'h3 : 4'($urandom % 16);
         if (wr && ad == 4'h2) applyStimulus(1, rd, ad, 8'($urandom) | 8'h80, ack, rxv, 8'($urandom), busy, rs, -1);
         else applyStimulus(wr, rd, ad, 8'($urandom), ack, rxv, 8'($urandom), busy, rs, -1);
      end

      WR_i = 0; RD_i = 0; TX_Ack_i = 0; RX_Valid_i = 0; RST_SYNC_i = 0;
      repeat (2) @(posedge CLK_i);
      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/spim_regs_fifo.md
Name: spim_regs_fifo

Overview:
- Next-generation host-side register bank for the eFPGA SPI master.
- Replaces single-byte TX/RX registers with parametrised TX and RX FIFOs, parametrised chip-select count, per-source interrupt enables and sticky overrun flags.
- Sits between the byte-wide host register bus and the SPI shift engine.
- Uses a valid/ack byte handshake to the engine instead of start/stop command bits.

Parameters:
FIFO_DEPTH, 4, entries per FIFO; power of 2, 2..16
NUM_CS, 8, chip-select outputs, 1..8

Ports:
CLK_i  in  1  clock
RST_i  in  1  reset, asynchronous, active-high
RST_SYNC_i  in  1  synchronous reset; same reset values as RST_i
WR_i  in  1  register write strobe, one cycle per access
RD_i  in  1  register read strobe; only side effect is RX pop
AD_i  in  4  register address
Data_i  in  8  write data
Data_o  out  8  read data, combinational from AD_i
Divisor_o  out  16  SCLK divisor
SPE_o, CPOL_o, CPHA_o, LSBFE_o  out  1 each  CTRL bits
CS_o  out  NUM_CS  chip-select register
TX_Data_o  out  8  TX FIFO head
TX_Valid_o  out  1  head valid and SPE=1
TX_Ack_i  in  1  engine consumed head byte (1-cycle pulse)
RX_Data_i  in  8  received byte
RX_Valid_i  in  1  received byte strobe
Busy_i  in  1  engine shifting
INTR_o  out  1  interrupt, registered

Behaviour:
- Register map:
  - 0x0 DIV[7:0], 0x1 DIV[15:8]; DIV resets to 0x0001.
  - 0x2 CTRL: [7]SPE, [3]CPOL, [2]CPHA, [0]LSBFE; other bits write-ignored, read 0.
  - 0x3 DATA: write pushes TX; read with RD_i pops RX.
  - 0x4 STATUS (RO): [0]TX_EMPTY, [1]TX_FULL, [2]RX_EMPTY, [3]RX_FULL, [4]Busy_i, [5]RX_OVR, [6]TX_OVR.
  - 0x5 CS: low NUM_CS bits; others read 0.
  - 0x6 IE: [0]TXE, [2]RXNE, [5]OVR.
  - 0x7 CMD (write-only, reads 0): [0] flush TX, [1] flush RX, [2] clear both overrun flags; self-clearing, acts in the write cycle.
  - 0x8 TX level, 0x9 RX level (0..FIFO_DEPTH).
  - 0xA-0xF read 0x00; writes ignored.
- Reset values: all registers and outputs 0 except DIV=0x0001. Both FIFOs empty. Overrun flags 0. INTR_o=0.
- TX push: WR_i@0x3 while not full stores the byte; the level updates next cycle.
  - Full and no same-cycle pop: byte dropped, TX_OVR set.
  - Full with same-cycle TX_Ack_i: push accepted, level unchanged.
- TX pop: TX_Ack_i with TX not empty pops. TX_Ack_i when empty is ignored.
- TX_Valid_o = SPE & !TX_EMPTY. With SPE=0, writes are still queued.
- RX push: RX_Valid_i while not full stores the byte.
  - Full without same-cycle pop: byte dropped, RX_OVR set.
  - Full with same-cycle pop: push accepted.
- RX pop: RD_i@0x3 pops. Data_o@0x3 shows the head, or 0x00 when empty; reading empty has no effect.
- Simultaneous push and pop: both take effect; pointers wrap mod FIFO_DEPTH; level holds.
- Flush beats any same-cycle push/pop on that FIFO. It does not clear overrun flags.
- CMD clear beats a same-cycle overrun set.
- Overrun flags are sticky until CMD[2] or reset.
- INTR_o (registered, 1-cycle latency) = SPE & ((IE0 & TX_EMPTY) | (IE2 & !RX_EMPTY) | (IE5 & (RX_OVR|TX_OVR))).
- RST_SYNC_i mid-transfer: FIFOs emptied and TX_Valid_o low next cycle. Outstanding TX_Ack_i/RX_Valid_i in that cycle are ignored.

Decomposition:
- Package spim_pkg: address constants (ADDR_DIVL..ADDR_RXLVL), STATUS/IE/CMD bit-position constants, DIV reset value.
- Sub-module spim_sync_fifo (parameters W=8, DEPTH):
  - Inputs: push, pop, flush.
  - Outputs: head, full, empty, level, and a drop pulse for push-when-full-without-pop.
- Instantiated twice.

Test Plan:
- Reset, then read 0x0-0x9 -> DIV=0x0001 (0x01, 0x00), STATUS=0x05, all others 0x00, INTR_o=0.
- SPE=1, write 0x11,0x22,0x33,0x44,0x55 to 0x3 with no ack -> TX level=4, TX_FULL=1, TX_OVR=1, TX_Data_o=0x11. Then 4 acks -> 0x22,0x33,0x44 presented, TX_EMPTY=1.
- With TX full, write 0x66 in the same cycle as TX_Ack_i -> no overrun; level stays 4; tail entry is 0x66.
- RX_Valid_i with 0xA5,0x5A; IE=0x04, SPE=1 -> INTR_o=1 one cycle after the first byte. RD@0x3 returns 0xA5 then 0x5A. INTR_o drops one cycle after the last pop.
- Fill RX, send a 5th byte -> RX_OVR=1. IE=0x20 raises INTR_o. CMD=0x04 clears RX_OVR; CMD=0x02 empties RX (STATUS[2]=1).
- Queue 3 TX bytes, assert RST_SYNC_i while Busy_i=1 -> next cycle TX_Valid_o=0, levels 0, DIV=0x0001, CS_o=0.
